// File: rtl/axil_master_ctrl_if.sv
// Command/response port plus AXI4-Lite master channels for axil_master_ctrl.
// The master modport is the controller's view; slave is the bench/slave view.
interface axil_master_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned DATA_W = 32;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] M_AXI_AWADDR;
  logic              M_AXI_AWVALID;
  logic              M_AXI_AWREADY;
  logic [DATA_W-1:0] M_AXI_WDATA;
  logic [3:0]        M_AXI_WSTRB;
  logic              M_AXI_WVALID;
  logic              M_AXI_WREADY;
  logic [1:0]        M_AXI_BRESP;
  logic              M_AXI_BVALID;
  logic              M_AXI_BREADY;
  logic [ADDR_W-1:0] M_AXI_ARADDR;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY;
  logic [DATA_W-1:0] M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;
  logic              M_AXI_RVALID;
  logic              M_AXI_RREADY;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/axil_master_ctrl.sv
// Single-outstanding AXI4-Lite master driven from a command/response port,
// with a per-transaction timeout so a hung slave cannot stall the caller.
module axil_master_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 rst,
  axil_master_ctrl_if.master  bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {S_IDLE, S_WA, S_WB, S_RA, S_RD, S_RSP} state_e;

  state_e              state_q, state_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic                to_q, to_d;
  logic                expired;

  // Expiry is judged on the incremented count so TIMEOUT busy cycles elapse.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign expired = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      to_q      <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      to_q      <= to_d;
    end
  end

  // Next state; a real response always takes priority over expiry.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    to_d      = to_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          rdata_d = '0;
          resp_d  = '0;
          to_d    = 1'b0;
          state_d = bus.cmd_we ? S_WA : S_RA;
        end
      end
      S_WA: begin
        cnt_d     = cnt_inc;
        aw_done_d = aw_done_q | bus.M_AXI_AWREADY;
        w_done_d  = w_done_q  | bus.M_AXI_WREADY;
        if (aw_done_d && w_done_d) begin
          state_d = S_WB;
        end else if (expired) begin
          resp_d  = 2'b11;
          to_d    = 1'b1;
          state_d = S_RSP;
        end
      end
      S_WB: begin
        cnt_d = cnt_inc;
        if (bus.M_AXI_BVALID) begin
          resp_d  = bus.M_AXI_BRESP;
          state_d = S_RSP;
        end else if (expired) begin
          resp_d  = 2'b11;
          to_d    = 1'b1;
          state_d = S_RSP;
        end
      end
      S_RA: begin
        cnt_d = cnt_inc;
        if (bus.M_AXI_ARREADY) begin
          state_d = S_RD;
        end else if (expired) begin
          resp_d  = 2'b11;
          to_d    = 1'b1;
          state_d = S_RSP;
        end
      end
      S_RD: begin
        cnt_d = cnt_inc;
        if (bus.M_AXI_RVALID) begin
          rdata_d = bus.M_AXI_RDATA;
          resp_d  = bus.M_AXI_RRESP;
          state_d = S_RSP;
        end else if (expired) begin
          resp_d  = 2'b11;
          to_d    = 1'b1;
          state_d = S_RSP;
        end
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is a register or a decode of registered state.
  always_comb begin
    bus.cmd_ready     = (state_q == S_IDLE);
    bus.rsp_valid     = (state_q == S_RSP);
    bus.rsp_rdata     = rdata_q;
    bus.rsp_resp      = resp_q;
    bus.rsp_timeout   = to_q;
    bus.M_AXI_AWADDR  = addr_q;
    bus.M_AXI_AWVALID = (state_q == S_WA) && !aw_done_q;
    bus.M_AXI_WDATA   = wdata_q;
    bus.M_AXI_WSTRB   = 4'hf;
    bus.M_AXI_WVALID  = (state_q == S_WA) && !w_done_q;
    bus.M_AXI_BREADY  = (state_q == S_WB);
    bus.M_AXI_ARADDR  = addr_q;
    bus.M_AXI_ARVALID = (state_q == S_RA);
    bus.M_AXI_RREADY  = (state_q == S_RD);
  end
endmodule

// File: tb/tb_axil_master_ctrl.sv
// Directed bench for axil_master_ctrl: one DUT with TIMEOUT=8, one with TIMEOUT=0.
module tb_axil_master_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  axil_master_ctrl_if #(.ADDR_W(32)) a ();
  axil_master_ctrl_if #(.ADDR_W(32)) b ();

  axil_master_ctrl #(.ADDR_W(32), .TIMEOUT(8)) dut_a (.clk(clk), .rst(rst), .bus(a));
  axil_master_ctrl #(.ADDR_W(32), .TIMEOUT(0)) dut_b (.clk(clk), .rst(rst), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a.cmd_valid = 0; a.cmd_we = 0; a.cmd_addr = '0; a.cmd_wdata = '0;
    a.M_AXI_AWREADY = 0; a.M_AXI_WREADY = 0; a.M_AXI_BRESP = '0; a.M_AXI_BVALID = 0;
    a.M_AXI_ARREADY = 0; a.M_AXI_RDATA = '0; a.M_AXI_RRESP = '0; a.M_AXI_RVALID = 0;
    b.cmd_valid = 0; b.cmd_we = 0; b.cmd_addr = '0; b.cmd_wdata = '0;
    b.M_AXI_AWREADY = 0; b.M_AXI_WREADY = 0; b.M_AXI_BRESP = '0; b.M_AXI_BVALID = 0;
    b.M_AXI_ARREADY = 0; b.M_AXI_RDATA = '0; b.M_AXI_RRESP = '0; b.M_AXI_RVALID = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a.cmd_ready, a.M_AXI_AWVALID, a.M_AXI_WVALID, a.M_AXI_BREADY,
         a.M_AXI_ARVALID, a.M_AXI_RREADY, a.rsp_valid, a.rsp_timeout} !== 8'b1000_0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 10000000",
        {a.cmd_ready, a.M_AXI_AWVALID, a.M_AXI_WVALID, a.M_AXI_BREADY,
         a.M_AXI_ARVALID, a.M_AXI_RREADY, a.rsp_valid, a.rsp_timeout});
    end
    checks++;
    if ({a.rsp_rdata, a.rsp_resp, a.M_AXI_AWADDR, a.M_AXI_WDATA, a.M_AXI_WSTRB} !== {32'h0, 2'b00, 32'h0, 32'h0, 4'hf}) begin
      errors++; $display("FAIL reset_data: got rdata=%h resp=%b awaddr=%h wdata=%h wstrb=%h expected 0/0/0/0/f",
        a.rsp_rdata, a.rsp_resp, a.M_AXI_AWADDR, a.M_AXI_WDATA, a.M_AXI_WSTRB);
    end
  endtask

  task automatic test_basic_write();
    a.cmd_valid = 1; a.cmd_we = 1; a.cmd_addr = 32'h000; a.cmd_wdata = 32'h1;
    a.M_AXI_AWREADY = 1; a.M_AXI_WREADY = 1; a.M_AXI_BVALID = 1; a.M_AXI_BRESP = 2'b00;
    tick(); a.cmd_valid = 0;
    checks++;
    if ({a.cmd_ready, a.M_AXI_AWVALID, a.M_AXI_WVALID, a.M_AXI_BREADY} !== 4'b0110) begin
      errors++; $display("FAIL wr_c1_valid: got %b expected 0110",
        {a.cmd_ready, a.M_AXI_AWVALID, a.M_AXI_WVALID, a.M_AXI_BREADY});
    end
    checks++;
    if ({a.M_AXI_AWADDR, a.M_AXI_WDATA, a.M_AXI_WSTRB} !== {32'h0, 32'h1, 4'hf}) begin
      errors++; $display("FAIL wr_c1_payload: got %h/%h/%h expected 0/1/f",
        a.M_AXI_AWADDR, a.M_AXI_WDATA, a.M_AXI_WSTRB);
    end
    tick();
    checks++;
    if ({a.M_AXI_AWVALID, a.M_AXI_WVALID, a.M_AXI_BREADY, a.rsp_valid} !== 4'b0010) begin
      errors++; $display("FAIL wr_c2_bready: got %b expected 0010",
        {a.M_AXI_AWVALID, a.M_AXI_WVALID, a.M_AXI_BREADY, a.rsp_valid});
    end
    tick();
    checks++;
    if ({a.rsp_valid, a.M_AXI_BREADY, a.rsp_resp, a.rsp_timeout, a.rsp_rdata} !== {1'b1, 1'b0, 2'b00, 1'b0, 32'h0}) begin
      errors++; $display("FAIL wr_c3_rsp: got valid=%b bready=%b resp=%b to=%b rdata=%h expected 1/0/00/0/0",
        a.rsp_valid, a.M_AXI_BREADY, a.rsp_resp, a.rsp_timeout, a.rsp_rdata);
    end
    tick();
    checks++;
    if ({a.rsp_valid, a.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL wr_c4_idle: got %b expected 01", {a.rsp_valid, a.cmd_ready});
    end
    idle_inputs();
  endtask

  task automatic test_delayed_aw();
    a.cmd_valid = 1; a.cmd_we = 1; a.cmd_addr = 32'h010; a.cmd_wdata = 32'hA5A5A5A5;
    a.M_AXI_AWREADY = 0; a.M_AXI_WREADY = 1;
    tick(); a.cmd_valid = 0;
    checks++;
    if ({a.M_AXI_AWVALID, a.M_AXI_WVALID, a.M_AXI_WDATA} !== {2'b11, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL daw_c1: got aw=%b w=%b wdata=%h expected 1/1/a5a5a5a5",
        a.M_AXI_AWVALID, a.M_AXI_WVALID, a.M_AXI_WDATA);
    end
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++;
      if ({a.M_AXI_AWVALID, a.M_AXI_WVALID, a.M_AXI_BREADY, a.M_AXI_AWADDR} !== {3'b100, 32'h010}) begin
        errors++; $display("FAIL daw_hold_c%0d: got aw=%b w=%b bready=%b addr=%h expected 1/0/0/00000010",
          c, a.M_AXI_AWVALID, a.M_AXI_WVALID, a.M_AXI_BREADY, a.M_AXI_AWADDR);
      end
    end
    a.M_AXI_AWREADY = 1; a.M_AXI_BVALID = 1;
    tick(); a.M_AXI_AWREADY = 0;
    checks++;
    if ({a.M_AXI_AWVALID, a.M_AXI_BREADY, a.rsp_valid} !== 3'b010) begin
      errors++; $display("FAIL daw_c5_bready: got %b expected 010",
        {a.M_AXI_AWVALID, a.M_AXI_BREADY, a.rsp_valid});
    end
    tick();
    checks++;
    if ({a.rsp_valid, a.rsp_resp} !== 3'b100) begin
      errors++; $display("FAIL daw_c6_rsp: got %b expected 100", {a.rsp_valid, a.rsp_resp});
    end
    tick();
    checks++;
    if (a.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL daw_c7_pulse: got %b expected 0", a.rsp_valid);
    end
    idle_inputs();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input int waits);
    a.cmd_valid = 1; a.cmd_we = 0; a.cmd_addr = addr;
    a.M_AXI_ARREADY = 1; a.M_AXI_RVALID = 0; a.M_AXI_RDATA = data; a.M_AXI_RRESP = 2'b00;
    tick(); a.cmd_valid = 0;
    checks++;
    if ({a.M_AXI_ARVALID, a.M_AXI_RREADY, a.M_AXI_ARADDR} !== {2'b10, addr}) begin
      errors++; $display("FAIL rd_c1_ar: got arv=%b rr=%b addr=%h expected 1/0/%h",
        a.M_AXI_ARVALID, a.M_AXI_RREADY, a.M_AXI_ARADDR, addr);
    end
    tick();
    checks++;
    if ({a.M_AXI_ARVALID, a.M_AXI_RREADY} !== 2'b01) begin
      errors++; $display("FAIL rd_c2_rready: got %b expected 01", {a.M_AXI_ARVALID, a.M_AXI_RREADY});
    end
    for (int w = 0; w < waits; w++) begin
      checks++;
      if ({a.rsp_valid, a.M_AXI_RREADY} !== 2'b01) begin
        errors++; $display("FAIL rd_wait%0d: got %b expected 01", w, {a.rsp_valid, a.M_AXI_RREADY});
      end
      tick();
    end
    a.M_AXI_RVALID = 1;
    tick(); a.M_AXI_RVALID = 0;
    checks++;
    if ({a.rsp_valid, a.M_AXI_RREADY, a.rsp_resp, a.rsp_timeout, a.rsp_rdata} !== {4'b1000, 1'b0, data}) begin
      errors++; $display("FAIL rd_rsp: got valid=%b rr=%b resp=%b to=%b rdata=%h expected 1/0/00/0/%h",
        a.rsp_valid, a.M_AXI_RREADY, a.rsp_resp, a.rsp_timeout, a.rsp_rdata, data);
    end
    tick();
    checks++;
    if ({a.rsp_valid, a.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL rd_after: got %b expected 01", {a.rsp_valid, a.cmd_ready});
    end
    idle_inputs();
  endtask

  task automatic test_read();
    do_read(32'h010, 32'hDEADBEEF, 2);
  endtask

  task automatic test_back_to_back();
    a.cmd_valid = 1; a.cmd_we = 1; a.cmd_addr = 32'h000; a.cmd_wdata = 32'h6;
    a.M_AXI_AWREADY = 1; a.M_AXI_WREADY = 1; a.M_AXI_BVALID = 1; a.M_AXI_BRESP = 2'b10;
    tick(); a.cmd_valid = 0;
    tick();
    tick();
    checks++;
    if ({a.rsp_valid, a.rsp_resp, a.rsp_timeout, a.cmd_ready} !== 5'b1_10_0_0) begin
      errors++; $display("FAIL slverr_rsp: got valid=%b resp=%b to=%b ready=%b expected 1/10/0/0",
        a.rsp_valid, a.rsp_resp, a.rsp_timeout, a.cmd_ready);
    end
    a.cmd_valid = 1; a.cmd_we = 0; a.cmd_addr = 32'h010;
    a.M_AXI_ARREADY = 1; a.M_AXI_RVALID = 1; a.M_AXI_RDATA = 32'hCAFE0001; a.M_AXI_RRESP = 2'b00;
    tick();
    checks++;
    if (a.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready: got %b expected 1", a.cmd_ready);
    end
    tick(); a.cmd_valid = 0;
    checks++;
    if ({a.cmd_ready, a.M_AXI_ARVALID} !== 2'b01) begin
      errors++; $display("FAIL b2b_arvalid: got %b expected 01", {a.cmd_ready, a.M_AXI_ARVALID});
    end
    tick();
    tick();
    checks++;
    if ({a.rsp_valid, a.rsp_resp, a.rsp_rdata} !== {3'b100, 32'hCAFE0001}) begin
      errors++; $display("FAIL b2b_rsp: got valid=%b resp=%b rdata=%h expected 1/00/cafe0001",
        a.rsp_valid, a.rsp_resp, a.rsp_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    a.cmd_valid = 1; a.cmd_we = 1; a.cmd_addr = 32'h000; a.cmd_wdata = 32'h2;
    tick(); a.cmd_valid = 0;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if ({a.M_AXI_AWVALID, a.M_AXI_WVALID, a.rsp_valid} !== 3'b110) begin
        errors++; $display("FAIL to_hold_c%0d: got %b expected 110",
          c, {a.M_AXI_AWVALID, a.M_AXI_WVALID, a.rsp_valid});
      end
      tick();
    end
    checks++;
    if ({a.M_AXI_AWVALID, a.M_AXI_WVALID, a.M_AXI_BREADY, a.rsp_valid, a.rsp_resp, a.rsp_timeout} !== 7'b0001_11_1) begin
      errors++; $display("FAIL to_rsp: got %b expected 0001111",
        {a.M_AXI_AWVALID, a.M_AXI_WVALID, a.M_AXI_BREADY, a.rsp_valid, a.rsp_resp, a.rsp_timeout});
    end
    tick();
    checks++;
    if ({a.rsp_valid, a.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL to_after: got %b expected 01", {a.rsp_valid, a.cmd_ready});
    end
  endtask

  task automatic test_no_timeout();
    int pulses;
    pulses = 0;
    b.cmd_valid = 1; b.cmd_we = 1; b.cmd_addr = 32'h000; b.cmd_wdata = 32'h2;
    tick(); b.cmd_valid = 0;
    for (int c = 0; c < 40; c++) begin
      if (b.rsp_valid === 1'b1) pulses++;
      tick();
    end
    checks++;
    if ({pulses == 0, b.M_AXI_AWVALID, b.M_AXI_WVALID} !== 3'b111) begin
      errors++; $display("FAIL no_timeout: got pulses=%0d aw=%b w=%b expected 0/1/1",
        pulses, b.M_AXI_AWVALID, b.M_AXI_WVALID);
    end
    do_reset();
    checks++;
    if ({b.cmd_ready, b.M_AXI_AWVALID, b.M_AXI_WVALID} !== 3'b100) begin
      errors++; $display("FAIL no_timeout_reset: got %b expected 100",
        {b.cmd_ready, b.M_AXI_AWVALID, b.M_AXI_WVALID});
    end
  endtask

  task automatic test_reset_in_rd();
    int pulses;
    pulses = 0;
    a.cmd_valid = 1; a.cmd_we = 0; a.cmd_addr = 32'h000; a.M_AXI_ARREADY = 1;
    tick(); a.cmd_valid = 0;
    tick();
    checks++;
    if (a.M_AXI_RREADY !== 1'b1) begin
      errors++; $display("FAIL rrd_in_rd: got %b expected 1", a.M_AXI_RREADY);
    end
    rst = 1;
    tick(); rst = 0;
    checks++;
    if ({a.M_AXI_RREADY, a.M_AXI_ARVALID, a.rsp_valid, a.cmd_ready} !== 4'b0001) begin
      errors++; $display("FAIL rrd_idle: got %b expected 0001",
        {a.M_AXI_RREADY, a.M_AXI_ARVALID, a.rsp_valid, a.cmd_ready});
    end
    for (int c = 0; c < 4; c++) begin
      if (a.rsp_valid === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL rrd_no_rsp: got %0d pulses expected 0", pulses);
    end
    idle_inputs();
    do_read(32'h000, 32'h12345678, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 0;
    idle_inputs();
    test_reset();
    test_basic_write();
    test_delayed_aw();
    test_read();
    test_back_to_back();
    test_timeout();
    test_no_timeout();
    test_reset_in_rd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_master_ctrl.md
Name: axil_master_ctrl

Overview:
- AXI4-Lite master (initiator) that drives the accelerator's AXI-Lite register slave (reg 0x000 {last,run,matw}, reg 0x010 control) from a simple command/response port.
- Used by on-chip sequencers and by the system bench to start and stop matrix loads and runs without a CPU.
- Issues exactly one single-beat transaction at a time.
- Has a per-transaction timeout so a hung slave cannot stall the sequencer.

Parameters:
- ADDR_W, 32, address width of cmd_addr and M_AXI_AWADDR/ARADDR.
- TIMEOUT, 255, cycles allowed from first VALID to response; 0 disables the timeout. Counter width is 16 bits.

Ports:
- clk  in  1  clock (AXI-Lite clock domain).
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle; command is accepted on cmd_valid & cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  32  write data; all 4 strobes are set.
- rsp_valid  out  1  one-cycle pulse at transaction end.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP as received; 2'b11 on timeout.
- rsp_timeout  out  1  timeout flag, valid with rsp_valid.
- M_AXI_AWADDR out ADDR_W; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out ADDR_W; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- All outputs are registered or decoded from the state register. Nothing is combinational from AXI inputs.
- Reset values: state=IDLE; cmd_ready=1 (decoded from IDLE); all VALID/READY outputs=0; rsp_valid=0; rsp_rdata=0; rsp_resp=0; rsp_timeout=0; addr/data registers=0; WSTRB=4'hf constant.
- Reset mid-transaction returns to IDLE next cycle with all VALIDs low. No response is emitted for the aborted command.
- States: IDLE, WA (AW/W pending), WB (await B), RA (await ARREADY), RD (await R), RSP.
- IDLE:
  - On command accept, latch addr/wdata/we.
  - Write goes to WA with AWVALID=WVALID=1.
  - Read goes to RA with ARVALID=1.
  - Clear the timeout counter.
- WA:
  - AWVALID and WVALID are held until their own handshake; each drops independently the cycle after its READY is sampled high.
  - AW and W may complete in either order or together.
  - When both are done, go to WB with BREADY=1.
  - Address and data are stable while VALID is high.
- WB: on BVALID, latch BRESP and go to RSP. BREADY is deasserted in RSP.
- RA: on ARREADY, drop ARVALID and go to RD with RREADY=1.
- RD: on RVALID, latch RDATA/RRESP and go to RSP.
- RSP: rsp_valid=1 for exactly one cycle, then IDLE. cmd_ready returns the cycle after RSP.
- Minimum latency (ready slave, same-cycle responses):
  - Accept at cycle 0, VALID at cycle 1, BREADY/RREADY at cycle 2, rsp_valid at cycle 3.
  - Back-to-back commands: one every 4 cycles.
- Timeout:
  - Counter increments every cycle outside IDLE/RSP.
  - When the count equals TIMEOUT (TIMEOUT != 0), all VALID/READY drop, rsp_resp=2'b11, rsp_timeout=1, and the state goes to RSP.
  - A response arriving in the same cycle as the timeout wins (normal completion).
  - After a timeout the AXI protocol is knowingly abandoned; recovery requires reset of both sides.
- No address decode; any address is forwarded unchanged.

Test Plan:
- Write addr 0x000 data 0x00000001, slave always ready, BRESP=00 -> AWVALID/WVALID high for 1 cycle (cycle 1); rsp_valid at cycle 3; rsp_resp=00; rsp_rdata=0; WSTRB=4'hf.
- Write addr 0x010 data 0xA5A5A5A5, WREADY immediate, AWREADY delayed 3 cycles -> WVALID drops after cycle 1; AWVALID held 4 cycles with stable address; BREADY only after both complete; one rsp pulse.
- Read addr 0x010, slave returns RDATA 0xDEADBEEF, RRESP=00 after 2 wait cycles -> ARVALID for 1 cycle; rsp_rdata=0xDEADBEEF; rsp_valid exactly 1 cycle.
- Write with BRESP=2'b10 -> rsp_resp=10, rsp_timeout=0; next command accepted the cycle after rsp_valid.
- TIMEOUT=8, slave never asserts AWREADY -> after 8 cycles outside IDLE, AWVALID/WVALID drop; rsp_resp=11, rsp_timeout=1. Same run with TIMEOUT=0 -> waits indefinitely.
- rst asserted for 1 cycle while in RD -> next cycle IDLE, RREADY=0, no rsp_valid, cmd_ready=1; a following read completes normally.
